// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// The pipeline decoder uses the same op codes.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit. The result is computed combinationally at
// accept time, held in shadow registers, and committed after a fixed busy window.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for an accepted start; MTHI/MTLO complete here
// ST_RUN  | busy; counter runs down and shadows commit at count 1
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, sq_mag, sr_mag, q_s, r_s, q_u, r_u, bu_safe;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
  assign a_mag   = A[31] ? (~A + 32'd1) : A;
  assign b_mag   = B[31] ? (~B + 32'd1) : B;
  assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign sq_mag  = a_mag / b_safe;
  assign sr_mag  = a_mag % b_safe;
  assign q_s     = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign r_s     = A[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign bu_safe = (B == 32'd0) ? 32'd1 : B;
  assign q_u     = A / bu_safe;
  assign r_u     = A % bu_safe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !req) begin
          case (op)
            OP_MULT: begin
              state_d = ST_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              sh_hi_d = prod_s[63:32];
              sh_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              state_d = ST_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              sh_hi_d = prod_u[63:32];
              sh_lo_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_RUN;
              cnt_d   = CNT_W'(DIV_CYCLES);
              // A zero divisor still takes the full latency but commits the old HI/LO.
              if (B == 32'd0) begin
                sh_hi_d = hi_q;
                sh_lo_d = lo_q;
              end else if (op == OP_DIV) begin
                sh_hi_d = r_s;
                sh_lo_d = q_s;
              end else begin
                sh_hi_d = r_u;
                sh_lo_d = q_u;
              end
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: latency, arithmetic corner cases,
// flush/reset behaviour and start-while-busy handling.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .req(req), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start for a single edge; returns in cycle t+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded) and returns in the first cycle with busy low.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", LO); end
  endtask

  task automatic test_mthi_mtlo();
    req = 1'b1;
    issue(OP_MTHI, 32'h1234, 32'd0);
    req = 1'b0;
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mthi_flushed got %h exp 00000000", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_flushed_busy got %b exp 0", busy); end
    issue(OP_MTHI, 32'h1234, 32'd0);
    checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mthi got %h exp 00001234", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    issue(OP_MTLO, 32'h5678, 32'd0);
    checks++; if (LO !== 32'h5678) begin errors++; $display("FAIL mtlo got %h exp 00005678", LO); end
    checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept got %h exp 00001234", HI); end
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_t1 got %b exp 1", busy); end
    checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin errors++; $display("FAIL mult_hilo_stable got %h_%h exp 00001234_00005678", HI, LO); end
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_latency got %0d exp 5", n); end
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_result got %h_%h exp ffffffff_fffffffa", HI, LO); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_latency got %0d exp 5", n); end
    checks++; if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_result got %h_%h exp fffffffe_00000001", HI, LO); end
  endtask

  task automatic test_div();
    int n;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_latency got %0d exp 10", n); end
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got %h_%h exp ffffffff_fffffffd", HI, LO); end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    checks++; if (HI !== 32'd1 || LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor got %h_%h exp 00000001_fffffffd", HI, LO); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (HI !== 32'd0 || LO !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h_%h exp 00000000_80000000", HI, LO); end
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu_latency got %0d exp 10", n); end
    checks++; if (HI !== 32'd1 || LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_result got %h_%h exp 00000001_7ffffffc", HI, LO); end
  endtask

  task automatic test_div_zero();
    int n;
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu_zero_latency got %0d exp 10", n); end
    checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL divu_zero_hilo got %h_%h exp 00000011_00000022", HI, LO); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_idle(n);
    checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL div_zero_hilo got %h_%h exp 00000011_00000022", HI, LO); end
  endtask

  task automatic test_req_in_run();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    req = 1'b1;
    wait_idle(n);
    req = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("FAIL req_run_latency got %0d exp 10", n); end
    checks++; if (HI !== 32'd2 || LO !== 32'd14) begin errors++; $display("FAIL req_run_result got %h_%h exp 00000002_0000000e", HI, LO); end
  endtask

  task automatic test_start_while_busy();
    int n;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    start = 1'b1; op = OP_MULT; A = 32'd5; B = 32'd5;
    tick(); tick(); tick();
    start = 1'b0;
    wait_idle(n);
    checks++; if (n + 3 !== 5) begin errors++; $display("FAIL busy_ignore_latency got %0d exp 5", n + 3); end
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL busy_ignore_result got %h_%h exp ffffffff_fffffffa", HI, LO); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_no_rerun got %b exp 0", busy); end
  endtask

  task automatic test_reset_in_run();
    int n;
    issue(OP_MULTU, 32'd3, 32'd4);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %b exp 0", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rst_run_hilo got %h_%h exp 00000000_00000000", HI, LO); end
    for (int i = 0; i < 8; i++) tick();
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rst_run_no_commit got %b %h_%h exp 0 00000000_00000000", busy, HI, LO); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(OP_MULT, 32'd2, 32'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_after_reset got %b exp 1", busy); end
    wait_idle(n);
    checks++; if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("FAIL start_after_reset_result got %h_%h exp 00000000_00000006", HI, LO); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    issue(OP_DIVU, 32'd50, 32'd8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd1) begin errors++; $display("FAIL b2b_first got %h_%h exp 00000000_00000001", HI, LO); end
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL b2b_latency got %0d exp 10", n); end
    checks++; if (HI !== 32'd2 || LO !== 32'd6) begin errors++; $display("FAIL b2b_second got %h_%h exp 00000002_00000006", HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_zero();
    test_req_in_run();
    test_start_while_busy();
    test_reset_in_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage instruction is an MDU operation this cycle.
REQ-006 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A  input  32  forwarded rs operand (post MF_ALUA mux).
REQ-008 SHALL have port B  input  32  forwarded rt operand (post MF_ALUB mux).
REQ-009 SHALL have port req  input  1  interrupt/exception flush; suppresses the E-stage operation.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.

Function
REQ-013 SHALL sample start/op/A/B on the rising edge; an accepted operation needs start=1, req=0, busy=0.
REQ-014 SHALL use two states, IDLE and RUN; busy=1 exactly in RUN.
REQ-015 SHALL, on accepted MULT/MULTU/DIV/DIVU, enter RUN, load counter with MULT_CYCLES or DIV_CYCLES, and latch the result in shadow registers.
REQ-016 SHALL decrement the counter each RUN cycle; when counter reaches 1, commit shadows to HI/LO and return to IDLE on that edge.
REQ-017 SHALL yield timing: start high in cycle t -> busy high cycles t+1..t+N -> new HI/LO and busy=0 visible in cycle t+N+1.
REQ-018 SHALL compute MULT as signed 32x32->64, MULTU unsigned; HI=bits[63:32], LO=bits[31:0].
REQ-019 SHALL compute DIV signed: LO=quotient truncated toward zero, HI=remainder with dividend's sign.
REQ-020 SHALL compute DIVU unsigned: LO=quotient, HI=remainder.
REQ-021 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0x00000000.
REQ-022 SHALL, for divisor B=0, run the full DIV_CYCLES but leave HI and LO unchanged.
REQ-023 SHALL execute accepted MTHI/MTLO in one edge (HI<=A or LO<=A), without asserting busy.
REQ-024 SHALL ignore start while busy=1 (upstream stall logic prevents it; no state change).
REQ-025 SHALL let an operation already in RUN complete when req rises (committed instruction); only the E-stage start is suppressed.
REQ-026 SHALL keep HI/LO stable and directly readable while busy; MFHI/MFLO stalling is upstream's job.
REQ-027 SHALL expose busy as a registered signal (no combinational path from start).

Reset
REQ-028 SHALL, when reset=1 on a rising edge, set state=IDLE, busy=0, counter=0, HI=0, LO=0, shadows=0.
REQ-029 SHALL let reset take priority over start, req and any in-flight operation, discarding it.
REQ-030 SHALL accept a new start on the first edge after reset deasserts.

Structure
REQ-031 SHALL take op encodings and default cycle counts from the shared macro header used by the pipeline decoder.
REQ-032 SHALL be one module with no sub-modules; arithmetic is plain combinational RTL feeding the shadow registers.

Verification
REQ-033 SHALL verify MULT A=0xFFFFFFFE, B=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 SHALL verify DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 SHALL verify DIVU A=7, B=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
REQ-036 SHALL verify MTHI A=0x1234 with req=1 -> HI unchanged; same with req=0 -> HI=0x1234 next cycle, busy stays 0.
REQ-037 SHALL verify MULTU start, reset asserted in cycle 3 of RUN -> busy=0, HI=LO=0; no later commit.
REQ-038 SHALL verify second MULT start while busy -> ignored; first result committed at t+6 unchanged.
